hwpf_prefetch_responder: RTL and testbench

- Responder end of the hardware-prefetcher request interface.
- Accepts CMO-prefetch requests (hpdcache_req_t) from the stride prefetcher engines, queues them in a small FIFO, drops duplicates of lines already being fetched, issues line refills on a memory-side req/rsp interface, and returns one hpdcache_rsp_t per request with need_rsp=1.
- Sits between the prefetch arbiter and the cache refill path.

---
 rtl/hpdcache_pkg.sv | 36 +++
 rtl/hwpf_responder_pkg.sv | 25 ++
 rtl/hwpf_responder_fifo.sv | 40 ++++
 rtl/hwpf_prefetch_responder.sv | 145 ++++++++++++++
 tb/tb_hwpf_prefetch_responder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - request/response types and widths shared with the cache core
package hpdcache_pkg;
  localparam int HPDCACHE_OFFSET_WIDTH      = 6;
  localparam int HPDCACHE_SET_WIDTH         = 6;
  localparam int HPDCACHE_NLINE_WIDTH       = 34;
  localparam int HPDCACHE_TAG_WIDTH         = HPDCACHE_NLINE_WIDTH - HPDCACHE_SET_WIDTH;
  localparam int HPDCACHE_PAGE_OFFSET_WIDTH = HPDCACHE_SET_WIDTH + HPDCACHE_OFFSET_WIDTH;

  typedef logic [HPDCACHE_NLINE_WIDTH-1:0] hpdcache_nline_t;
  typedef logic [3:0] hpdcache_req_op_t;
  typedef logic [2:0] hpdcache_req_size_t;
  typedef logic [2:0] hpdcache_req_sid_t;
  typedef logic [5:0] hpdcache_req_tid_t;

  localparam hpdcache_req_op_t   HPDCACHE_REQ_LOAD            = 4'h0;
  localparam hpdcache_req_op_t   HPDCACHE_REQ_STORE           = 4'h1;
  localparam hpdcache_req_op_t   HPDCACHE_REQ_CMO             = 4'h8;
  localparam hpdcache_req_size_t HPDCACHE_REQ_CMO_PREFETCH    = 3'h0;
  localparam hpdcache_req_size_t HPDCACHE_REQ_CMO_INVAL_NLINE = 3'h1;

  typedef struct packed {
    logic [HPDCACHE_PAGE_OFFSET_WIDTH-1:0] addr_offset;
    hpdcache_req_op_t                      op;
    hpdcache_req_size_t                    size;
    hpdcache_req_sid_t                     sid;
    hpdcache_req_tid_t                     tid;
    logic                                  need_rsp;
    logic [HPDCACHE_TAG_WIDTH-1:0]         addr_tag;
  } hpdcache_req_t;

  typedef struct packed {
    hpdcache_req_sid_t sid;
    hpdcache_req_tid_t tid;
    logic              error;
  } hpdcache_rsp_t;
endpackage

// File: rtl/hwpf_responder_pkg.sv
// rtl/hwpf_responder_pkg.sv - slot, queue entry and dispatch state types for the prefetch responder
package hwpf_responder_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_MEM_REQ} disp_state_e;

  typedef struct packed {
    logic                          valid;
    hpdcache_pkg::hpdcache_nline_t nline;
    hpdcache_pkg::hpdcache_req_sid_t sid;
    hpdcache_pkg::hpdcache_req_tid_t tid;
    logic                          need_rsp;
  } slot_t;

  typedef struct packed {
    hpdcache_pkg::hpdcache_nline_t   nline;
    logic                            legal;
    hpdcache_pkg::hpdcache_req_sid_t sid;
    hpdcache_pkg::hpdcache_req_tid_t tid;
    logic                            need_rsp;
  } fifo_entry_t;

  function automatic logic is_legal_prefetch(hpdcache_pkg::hpdcache_req_op_t op,
                                             hpdcache_pkg::hpdcache_req_size_t size);
    return (op == hpdcache_pkg::HPDCACHE_REQ_CMO) && (size == hpdcache_pkg::HPDCACHE_REQ_CMO_PREFETCH);
  endfunction
endpackage

// File: rtl/hwpf_responder_fifo.sv
// rtl/hwpf_responder_fifo.sv - generic synchronous FIFO, head visible while not empty
module hwpf_responder_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices meet.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/hwpf_prefetch_responder.sv
// rtl/hwpf_prefetch_responder.sv - queues prefetch CMOs, filters duplicates, issues line refills, answers requesters
module hwpf_prefetch_responder
  import hpdcache_pkg::*;
  import hwpf_responder_pkg::*;
#(
  parameter int  FIFO_DEPTH      = 4,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int ID_W            = $clog2(MAX_OUTSTANDING)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  hpdcache_req_t                   req_i,
  output logic                            rsp_valid_o,
  output hpdcache_rsp_t                   rsp_o,
  output logic                            mem_req_valid_o,
  input  logic                            mem_req_ready_i,
  output logic [HPDCACHE_NLINE_WIDTH-1:0] mem_req_nline_o,
  output logic [ID_W-1:0]                 mem_req_id_o,
  input  logic                            mem_rsp_valid_i,
  input  logic [ID_W-1:0]                 mem_rsp_id_i,
  output logic                            busy_o,
  output logic [ID_W:0]                   outstanding_o
);
  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        unused_offset_bits;

  assign req_ready_o        = enable_i & ~fifo_full;
  assign unused_offset_bits = ^req_i.addr_offset[HPDCACHE_OFFSET_WIDTH-1:0];

  always_comb begin
    push_entry          = '0;
    push_entry.nline    = {req_i.addr_tag, req_i.addr_offset[HPDCACHE_PAGE_OFFSET_WIDTH-1:HPDCACHE_OFFSET_WIDTH]};
    push_entry.legal    = is_legal_prefetch(req_i.op, req_i.size);
    push_entry.sid      = req_i.sid;
    push_entry.tid      = req_i.tid;
    push_entry.need_rsp = req_i.need_rsp;
  end

  hwpf_responder_fifo #(.DEPTH(FIFO_DEPTH), .T(fifo_entry_t)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (req_valid_i & req_ready_o),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  disp_state_e     state_q;
  slot_t           slots_q [MAX_OUTSTANDING];
  logic [ID_W-1:0] mem_id_q;
  logic            done;
  logic            done_rsp;
  logic            dup_hit;
  logic            free_found;
  logic [ID_W-1:0] free_idx;
  logic [ID_W:0]   out_cnt;
  logic            in_check;
  logic            check_rsp_case;
  logic            check_emit;
  logic            check_retire;
  logic            alloc;

  assign done     = mem_rsp_valid_i & slots_q[mem_rsp_id_i].valid;
  assign done_rsp = done & slots_q[mem_rsp_id_i].need_rsp;

  // Descending scan so the lowest free index is the one left in free_idx.
  always_comb begin
    dup_hit    = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    out_cnt    = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (slots_q[i].valid) begin
        out_cnt = out_cnt + {{ID_W{1'b0}}, 1'b1};
        if (slots_q[i].nline == head.nline) dup_hit = 1'b1;
      end else begin
        free_found = 1'b1;
        free_idx   = ID_W'(i);
      end
    end
  end

  // A completion owns rsp_o; a CHECK answer in the same cycle waits and keeps its head.
  assign in_check       = (state_q == ST_CHECK) & ~fifo_empty;
  assign check_rsp_case = ~head.legal | dup_hit;
  assign check_emit     = in_check & check_rsp_case & head.need_rsp;
  assign check_retire   = in_check & check_rsp_case & ~(check_emit & done_rsp);
  assign alloc          = in_check & ~check_rsp_case & free_found;
  assign fifo_pop       = check_retire | alloc;

  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_o       = '0;
    if (done_rsp) begin
      rsp_valid_o = 1'b1;
      rsp_o.sid   = slots_q[mem_rsp_id_i].sid;
      rsp_o.tid   = slots_q[mem_rsp_id_i].tid;
    end else if (check_emit) begin
      rsp_valid_o = 1'b1;
      rsp_o.sid   = head.sid;
      rsp_o.tid   = head.tid;
      rsp_o.error = ~head.legal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      mem_id_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) slots_q[i] <= '0;
    end else begin
      if (done) slots_q[mem_rsp_id_i].valid <= 1'b0;
      case (state_q)
        ST_IDLE:    if (!fifo_empty) state_q <= ST_CHECK;
        ST_CHECK: begin
          if (check_retire) begin
            state_q <= ST_IDLE;
          end else if (alloc) begin
            slots_q[free_idx] <= '{valid: 1'b1, nline: head.nline, sid: head.sid,
                                   tid: head.tid, need_rsp: head.need_rsp};
            mem_id_q          <= free_idx;
            state_q           <= ST_MEM_REQ;
          end
        end
        ST_MEM_REQ: if (mem_req_ready_i) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_valid_o = (state_q == ST_MEM_REQ);
  assign mem_req_id_o    = mem_id_q;
  assign mem_req_nline_o = slots_q[mem_id_q].nline;
  assign outstanding_o   = out_cnt;
  assign busy_o          = ~fifo_empty | (out_cnt != '0) | (state_q != ST_IDLE);
endmodule

// File: tb/tb_hwpf_prefetch_responder.sv
// tb/tb_hwpf_prefetch_responder.sv - directed vectors, corner sequences and a randomized scoreboard run
module tb_hwpf_prefetch_responder;
  import hpdcache_pkg::*;

  localparam int ID_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, enable_i, req_valid_i, req_ready_o, rsp_valid_o;
  logic mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i, busy_o;
  hpdcache_req_t   req_i;
  hpdcache_rsp_t   rsp_o;
  hpdcache_nline_t mem_req_nline_o;
  logic [ID_W-1:0] mem_req_id_o, mem_rsp_id_i;
  logic [ID_W:0]   outstanding_o;

  hwpf_prefetch_responder #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .rsp_valid_o(rsp_valid_o), .rsp_o(rsp_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_nline_o(mem_req_nline_o), .mem_req_id_o(mem_req_id_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_id_i(mem_rsp_id_i),
    .busy_o(busy_o), .outstanding_o(outstanding_o)
  );

  int tests = 0;
  int errors = 0;

  typedef struct packed { hpdcache_nline_t nline; logic [ID_W-1:0] id; } mem_ev_t;
  typedef struct packed { logic [8:0] key; logic err; } exp_t;
  typedef struct {
    logic [3:0] op; logic [2:0] size; hpdcache_nline_t nline; logic [2:0] sid; logic [5:0] tid;
    logic need; logic c2_rsp; logic err; logic mem;
  } vec_t;

  mem_ev_t         mem_log[$];
  hpdcache_rsp_t   rsp_log[$];
  exp_t            exp_q[$];
  logic            inflight_v [4];
  hpdcache_nline_t inflight_nline [4];
  logic            auto_rsp = 1'b0;
  logic            rand_phase = 1'b0;
  vec_t            vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic manual_rsp(input logic [ID_W-1:0] id);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_id_i    = id;
    inflight_v[id]  = 1'b0;
  endtask

  // Observes the memory side and responses, then advances to just after the next edge.
  task automatic tick();
    logic bad;
    @(negedge clk);
    if (mem_req_valid_o && mem_req_ready_i) begin
      bad = inflight_v[mem_req_id_o];
      for (int j = 0; j < 4; j++)
        if (inflight_v[j] && inflight_nline[j] == mem_req_nline_o) bad = 1'b1;
      if (rand_phase && (mem_req_nline_o < 34'h1000 || mem_req_nline_o > 34'h1007)) bad = 1'b1;
      chk("mem_issue_unique_legal", bad, 1'b0);
      inflight_v[mem_req_id_o]     = 1'b1;
      inflight_nline[mem_req_id_o] = mem_req_nline_o;
      mem_log.push_back('{nline: mem_req_nline_o, id: mem_req_id_o});
    end
    if (rsp_valid_o) rsp_log.push_back(rsp_o);
    @(posedge clk);
    #1;
    mem_rsp_valid_i = 1'b0;
    if (auto_rsp && $urandom_range(0, 2) == 0) begin
      int k;
      k = $urandom_range(0, 3);
      if (inflight_v[k]) manual_rsp(ID_W'(k));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [2:0] size, input hpdcache_nline_t nline,
                           input logic [2:0] sid, input logic [5:0] tid, input logic need);
    req_i             = '0;
    req_i.op          = op;
    req_i.size        = size;
    req_i.sid         = sid;
    req_i.tid         = tid;
    req_i.need_rsp    = need;
    req_i.addr_tag    = nline[33:6];
    req_i.addr_offset = {nline[5:0], 6'b0};
    req_valid_i       = 1'b1;
  endtask

  task automatic send(input hpdcache_nline_t nline, input logic [2:0] sid, input logic [5:0] tid);
    logic ok;
    ok = 1'b0;
    drive_req(HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, nline, sid, tid, 1'b1);
    for (int k = 0; k < 50 && !ok; k++) begin
      settle();
      ok = req_ready_o;
      tick();
    end
    req_valid_i = 1'b0;
    chk("send_accepted", ok, 1'b1);
  endtask

  task automatic clear_logs();
    mem_log.delete();
    rsp_log.delete();
  endtask

  initial begin
    int acc;
    int sent;
    logic [8:0] seq;
    logic legal, need, accepted;
    logic [8:0] cur_key;
    logic cur_err, cur_need, found;

    vecs[0] = '{HPDCACHE_REQ_CMO,  HPDCACHE_REQ_CMO_PREFETCH,    34'h100, 3'd1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{HPDCACHE_REQ_LOAD, HPDCACHE_REQ_CMO_PREFETCH,    34'h104, 3'd2, 6'd4, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{HPDCACHE_REQ_CMO,  HPDCACHE_REQ_CMO_INVAL_NLINE, 34'h108, 3'd3, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{HPDCACHE_REQ_LOAD, HPDCACHE_REQ_CMO_PREFETCH,    34'h10c, 3'd4, 6'd6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{HPDCACHE_REQ_CMO,  HPDCACHE_REQ_CMO_PREFETCH,    34'h110, 3'd5, 6'd7, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int j = 0; j < 4; j++) begin inflight_v[j] = 1'b0; inflight_nline[j] = '0; end
    rst_i = 1'b1; enable_i = 1'b0; req_valid_i = 1'b0; req_i = '0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_id_i = '0;
    idle(2);
    rst_i = 1'b0;
    settle();
    chk("reset_rsp_valid", rsp_valid_o, 1'b0);
    chk("reset_mem_req_valid", mem_req_valid_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_outstanding", outstanding_o, 0);
    chk("reset_req_ready_disabled", req_ready_o, 1'b0);
    enable_i = 1'b1;
    tick();

    // Single-request latency vectors from an idle responder.
    for (int v = 0; v < 5; v++) begin
      drive_req(vecs[v].op, vecs[v].size, vecs[v].nline, vecs[v].sid, vecs[v].tid, vecs[v].need);
      settle(); chk("vec_req_ready", req_ready_o, 1'b1); tick();
      req_valid_i = 1'b0;
      settle(); chk("vec_c1_rsp", rsp_valid_o, 1'b0); tick();
      settle();
      chk("vec_c2_rsp", rsp_valid_o, vecs[v].c2_rsp);
      if (vecs[v].c2_rsp) chk("vec_c2_rsp_fields", {rsp_o.sid, rsp_o.tid, rsp_o.error},
                              {vecs[v].sid, vecs[v].tid, vecs[v].err});
      tick();
      settle();
      chk("vec_c3_mem_valid", mem_req_valid_o, vecs[v].mem);
      if (vecs[v].mem) begin
        chk("vec_c3_mem_line_id", {mem_req_nline_o, mem_req_id_o}, {vecs[v].nline, 2'd0});
        tick();
        settle(); chk("vec_outstanding_1", outstanding_o, 1); tick();
        manual_rsp(2'd0);
        settle();
        chk("vec_done_rsp", rsp_valid_o, vecs[v].need);
        if (vecs[v].need) chk("vec_done_fields", {rsp_o.sid, rsp_o.tid, rsp_o.error},
                              {vecs[v].sid, vecs[v].tid, 1'b0});
        tick();
        settle(); chk("vec_outstanding_0", outstanding_o, 0);
      end
      chk("vec_busy_drained", busy_o, 1'b0);
      tick();
    end

    // Duplicate line: one refill, immediate answer for the second request.
    clear_logs();
    send(34'h200, 3'd2, 6'd5);
    send(34'h200, 3'd2, 6'd6);
    idle(10);
    chk("dup_mem_count", mem_log.size(), 1);
    foreach (mem_log[i]) chk("dup_mem_line", mem_log[i].nline, 34'h200);
    chk("dup_rsp_count", rsp_log.size(), 1);
    foreach (rsp_log[i]) chk("dup_rsp_fields", {rsp_log[i].sid, rsp_log[i].tid, rsp_log[i].error}, {3'd2, 6'd6, 1'b0});
    manual_rsp(2'd0);
    idle(3);
    chk("dup_rsp_count_after", rsp_log.size(), 2);
    if (rsp_log.size() == 2)
      chk("dup_first_rsp", {rsp_log[1].sid, rsp_log[1].tid, rsp_log[1].error}, {3'd2, 6'd5, 1'b0});
    chk("dup_busy", busy_o, 1'b0);

    // Five lines with refills withheld: four slots fill, fifth waits for slot 2.
    clear_logs();
    for (int i = 0; i < 5; i++) send(34'h300 + 34'(i), 3'd1, 6'(10 + i));
    idle(20);
    chk("five_mem_count", mem_log.size(), 4);
    foreach (mem_log[i]) chk("five_mem_id", mem_log[i].id, i);
    chk("five_outstanding", outstanding_o, 4);
    chk("five_busy", busy_o, 1'b1);
    manual_rsp(2'd2);
    settle();
    chk("five_slot2_rsp", {rsp_valid_o, rsp_o.sid, rsp_o.tid, rsp_o.error}, {1'b1, 3'd1, 6'd12, 1'b0});
    tick();
    idle(5);
    chk("five_mem_count_after", mem_log.size(), 5);
    if (mem_log.size() == 5) chk("five_fifth_issue", {mem_log[4].nline, mem_log[4].id}, {34'h304, 2'd2});
    for (int i = 0; i < 4; i++) begin manual_rsp(ID_W'(i)); tick(); end
    idle(3);
    chk("five_rsp_total", rsp_log.size(), 5);
    chk("five_drained", {busy_o, outstanding_o}, 0);

    // FIFO plus held refill request fill up; disabling keeps busy until drained.
    clear_logs();
    mem_req_ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive_req(HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 34'h400 + 34'(acc), 3'd3, 6'(acc), 1'b1);
      settle();
      if (req_ready_o) acc++;
      tick();
    end
    req_valid_i = 1'b0;
    chk("fill_accepts", acc, 5);
    settle(); chk("fill_ready_low", req_ready_o, 1'b0);
    enable_i = 1'b0;
    tick();
    settle();
    chk("disable_ready_busy", {req_ready_o, busy_o}, {1'b0, 1'b1});
    mem_req_ready_i = 1'b1;
    auto_rsp = 1'b1;
    for (int k = 0; k < 400 && busy_o; k++) tick();
    auto_rsp = 1'b0;
    idle(1);
    settle();
    chk("disable_drained", {busy_o, req_ready_o}, 2'b00);
    chk("disable_rsp_total", rsp_log.size(), 5);
    enable_i = 1'b1;

    // Reset with two refills in flight forgets them.
    clear_logs();
    send(34'h500, 3'd4, 6'd1);
    send(34'h501, 3'd4, 6'd2);
    idle(10);
    chk("rst_pre_outstanding", outstanding_o, 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int j = 0; j < 4; j++) inflight_v[j] = 1'b0;
    settle();
    chk("rst_outputs", {rsp_valid_o, mem_req_valid_o, busy_o, outstanding_o}, 0);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_id_i    = 2'd0;
    settle();
    chk("rst_stale_rsp", rsp_valid_o, 1'b0);
    tick();
    settle();
    chk("rst_after_stale", {busy_o, outstanding_o}, 0);

    // Randomized traffic against a response scoreboard.
    clear_logs();
    exp_q.delete();
    rand_phase = 1'b1;
    auto_rsp   = 1'b1;
    seq  = '0;
    sent = 0;
    cur_key = '0; cur_err = 1'b0; cur_need = 1'b0;
    for (int c = 0; c < 4000 && sent < 200; c++) begin
      if (!req_valid_i && $urandom_range(0, 2) != 0) begin
        legal = ($urandom_range(0, 3) != 0);
        need  = ($urandom_range(0, 4) != 0);
        if (legal)
          drive_req(HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_PREFETCH, 34'h1000 + 34'($urandom_range(0, 7)), seq[8:6], seq[5:0], need);
        else if ($urandom_range(0, 1) == 1)
          drive_req(HPDCACHE_REQ_LOAD, HPDCACHE_REQ_CMO_PREFETCH, 34'h2000 + 34'($urandom_range(0, 7)), seq[8:6], seq[5:0], need);
        else
          drive_req(HPDCACHE_REQ_CMO, HPDCACHE_REQ_CMO_INVAL_NLINE, 34'h2000 + 34'($urandom_range(0, 7)), seq[8:6], seq[5:0], need);
        cur_key = seq; cur_err = ~legal; cur_need = need;
        seq = seq + 9'd1;
      end
      mem_req_ready_i = ($urandom_range(0, 3) != 0);
      enable_i        = ($urandom_range(0, 9) != 0);
      settle();
      accepted = req_valid_i & req_ready_o;
      if (accepted) begin
        if (cur_need) exp_q.push_back('{key: cur_key, err: cur_err});
        sent++;
      end
      tick();
      if (accepted) req_valid_i = 1'b0;
    end
    req_valid_i     = 1'b0;
    enable_i        = 1'b1;
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < 3000 && busy_o; k++) tick();
    idle(2);
    chk("rand_drained", {busy_o, outstanding_o}, 0);
    foreach (rsp_log[i]) begin
      found = 1'b0;
      for (int j = 0; j < exp_q.size() && !found; j++) begin
        if (exp_q[j].key == {rsp_log[i].sid, rsp_log[i].tid}) begin
          found = 1'b1;
          chk("rand_rsp_error", rsp_log[i].error, exp_q[j].err);
          exp_q.delete(j);
        end
      end
      if (!found) chk("rand_unexpected_rsp", {rsp_log[i].sid, rsp_log[i].tid}, 9'h1ff);
    end
    chk("rand_missing_rsp", exp_q.size(), 0);
    rand_phase = 1'b0;
    auto_rsp   = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
